// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters with registered syncs, visible-region flag and start pulses.
// Define VGA_TIMING_ALIGN_EN to delay hsync/vsync/video_on/blank_n by one pixel for a registered framebuffer read.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       blank_n,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic       hs_nxt, vs_nxt, vid_nxt;
    logic       hsync_p0, vsync_p0, video_p0;

    // Outputs are decoded from the next count so they line up with the counter after the same edge
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
        hs_nxt  = !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
        vs_nxt  = !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
        vid_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync_p0    <= 1'b1;
            vsync_p0    <= 1'b1;
            video_p0    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Pulses drop on idle cycles so they never stretch past one clk
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (clk_en) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                hsync_p0    <= hs_nxt;
                vsync_p0    <= vs_nxt;
                video_p0    <= vid_nxt;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

`ifdef VGA_TIMING_ALIGN_EN
    logic hsync_p1, vsync_p1, video_p1;

    // One extra pixel of delay to match the registered framebuffer read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            video_p1 <= 1'b1;
        end else if (clk_en) begin
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            video_p1 <= video_p0;
        end
    end

    assign hsync    = hsync_p1;
    assign vsync    = vsync_p1;
    assign video_on = video_p1;
`else
    assign hsync    = hsync_p0;
    assign vsync    = vsync_p0;
    assign video_on = video_p0;
`endif

    assign blank_n = video_on;
    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default horizontal timing, shortened vertical timing (13 lines).
module tb_vga_timing_gen;

`ifdef VGA_TIMING_ALIGN_EN
    localparam int AL = 1;
`else
    localparam int AL = 0;
`endif

    localparam int S_HS = 0, S_VS = 1, S_VID = 2, S_BLK = 3;
    localparam int S_PX = 4, S_PY = 5, S_LS = 6, S_FS = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_en;
    logic       hsync, vsync, video_on, blank_n;
    logic [9:0] pixel_x, pixel_y;
    logic       line_start, frame_start;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(6),   .V_FP(2),  .V_SYNC(2),  .V_BP(3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_en     (clk_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .blank_n    (blank_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   ncyc  = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic int get_sig(input int s);
        case (s)
            S_HS:    return int'(hsync);
            S_VS:    return int'(vsync);
            S_VID:   return int'(video_on);
            S_BLK:   return int'(blank_n);
            S_PX:    return int'(pixel_x);
            S_PY:    return int'(pixel_y);
            S_LS:    return int'(line_start);
            default: return int'(frame_start);
        endcase
    endfunction

    // Called just after a posedge: d clk edges later the state is seen at negedge ncyc+1+d.
    task automatic exp_in(input int d, input int s, input int v, input string nm);
        exp_t e;
        e.cyc  = ncyc + 1 + d;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: pops every expectation due at this negedge and compares.
    always @(negedge clk) begin
        ncyc++;
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            exp_t e;
            int   act;
            e = q.pop_front();
            total++;
            if (e.cyc < ncyc) begin
                bad++;
                $display("FAIL %s missed at cyc=%0d (now %0d)", e.name, e.cyc, ncyc);
            end else begin
                act = get_sig(e.sig);
                if (act != e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d", e.name, ncyc, act, e.val);
                end
            end
        end
    end

    task automatic exp_reset_vals(input int d, input string tag);
        exp_in(d, S_HS, 1, {tag, "_hs"});
        exp_in(d, S_VS, 1, {tag, "_vs"});
        exp_in(d, S_VID, 1, {tag, "_vid"});
        exp_in(d, S_BLK, 1, {tag, "_blk"});
        exp_in(d, S_PX, 0, {tag, "_px"});
        exp_in(d, S_PY, 0, {tag, "_py"});
        exp_in(d, S_LS, 0, {tag, "_ls"});
        exp_in(d, S_FS, 0, {tag, "_fs"});
    endtask

    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_reset_vals(0, "rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Free-running frame: k edges after release -> h = k%800, v = (k/800)%13
        exp_in(1, S_PX, 1, "first_px");
        exp_in(1, S_PY, 0, "first_py");
        exp_in(1, S_LS, 0, "first_ls");
        exp_in(639 + AL, S_VID, 1, "vid_h639");
        exp_in(640 + AL, S_VID, 0, "vid_h640");
        exp_in(640 + AL, S_BLK, 0, "blk_h640");
        exp_in(655 + AL, S_HS, 1, "hs_h655");
        exp_in(656 + AL, S_HS, 0, "hs_h656");
        exp_in(751 + AL, S_HS, 0, "hs_h751");
        exp_in(752 + AL, S_HS, 1, "hs_h752");
        exp_in(799, S_PX, 799, "px_h799");
        exp_in(799, S_LS, 0, "ls_h799");
        exp_in(800, S_LS, 1, "ls_line1");
        exp_in(800, S_PX, 0, "px_wrap");
        exp_in(800, S_PY, 1, "py_line1");
        exp_in(800, S_FS, 0, "fs_line1");
        exp_in(801, S_LS, 0, "ls_one_clk");
        exp_in(4000 + AL, S_VID, 1, "vid_v5h0");
        exp_in(4639 + AL, S_VID, 1, "vid_v5h639");
        exp_in(4640 + AL, S_VID, 0, "vid_v5h640");
        exp_in(4800 + AL, S_VID, 0, "vid_v6h0");
        exp_in(6399 + AL, S_VS, 1, "vs_v7");
        exp_in(6400 + AL, S_VS, 0, "vs_v8");
        exp_in(7999 + AL, S_VS, 0, "vs_v9");
        exp_in(8000 + AL, S_VS, 1, "vs_v10");
        exp_in(10399, S_FS, 0, "fs_before");
        exp_in(10399, S_PY, 12, "py_last");
        exp_in(10399, S_PX, 799, "px_last");
        exp_in(10400, S_FS, 1, "fs_frame");
        exp_in(10400, S_LS, 1, "ls_frame");
        exp_in(10400, S_PX, 0, "px_frame");
        exp_in(10400, S_PY, 0, "py_frame");
        exp_in(10401, S_FS, 0, "fs_one_clk");
        exp_in(10401, S_LS, 0, "ls_after_frame");
        exp_in(11200, S_LS, 1, "ls_f1_line1");
        exp_in(11200, S_FS, 0, "fs_f1_line1");
        exp_in(12299, S_PX, 299, "px_pre_rst");
        exp_in(12299, S_PY, 2, "py_pre_rst");

        // Asynchronous reset mid-line at (h=300, v=2)
        repeat (12300) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_reset_vals(0, "arst");
        exp_reset_vals(1, "arst_hold");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // clk_en toggling: edge j advances iff j odd, so h = (j+1)/2
        exp_in(0, S_PX, 0, "rel_px");
        exp_in(0, S_LS, 0, "rel_ls");
        exp_in(1, S_PX, 1, "rel1_px");
        exp_in(1, S_PY, 0, "rel1_py");
        exp_in(1, S_LS, 0, "rel1_ls");
        exp_in(1, S_FS, 0, "rel1_fs");
        exp_in(2, S_PX, 1, "hold_px");
        exp_in(3, S_PX, 2, "adv_px");
        exp_in(1278 + 2 * AL, S_VID, 1, "tg_vid639");
        exp_in(1279 + 2 * AL, S_VID, 0, "tg_vid640");
        exp_in(1280 + 2 * AL, S_VID, 0, "tg_vid_hold");
        exp_in(1310 + 2 * AL, S_HS, 1, "tg_hs655");
        exp_in(1311 + 2 * AL, S_HS, 0, "tg_hs656");
        exp_in(1312 + 2 * AL, S_HS, 0, "tg_hs_hold");
        exp_in(1598, S_PX, 799, "tg_px799");
        exp_in(1598, S_LS, 0, "tg_ls_pre");
        exp_in(1599, S_LS, 1, "tg_ls1");
        exp_in(1599, S_PX, 0, "tg_px_wrap");
        exp_in(1599, S_PY, 1, "tg_py1");
        exp_in(1599, S_FS, 0, "tg_fs");
        exp_in(1600, S_LS, 0, "tg_ls_nostretch");
        exp_in(1600, S_PX, 0, "tg_px_hold");
        exp_in(3198, S_LS, 0, "tg_ls2_pre");
        exp_in(3199, S_LS, 1, "tg_ls2");
        exp_in(3199, S_PY, 2, "tg_py2");
        exp_in(3200, S_LS, 0, "tg_ls2_nostretch");
        for (int j = 1; j <= 3200; j++) begin
            @(posedge clk);
            #1;
            clk_en = ~clk_en;
        end

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL unchecked remaining=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
